// File: rtl/ether_tx.sv
`default_nettype none
// ============================================================================
// Module      : ether_tx
// Description : RMII transmit framer. A start pulse produces preamble+SFD,
//               the upstream payload dibits, a reflected CRC-32 FCS and the
//               inter-frame gap on the 2-bit RMII transmit bus. Upstream is
//               paced with data_request.
// Ports       : clk             - 50 MHz RMII reference clock
//               rstn            - asynchronous active-low reset
//               preamble_signal - one-cycle frame start request
//               axiiv / axiid   - payload dibit valid / dibit (bit 0 first)
//               data_request    - high while payload is accepted
//               axiov / axiod   - eth_txen / eth_txd
//               busy            - start accepted through end of IFG
//               truncated       - sticky, payload cap reached
//               led             - toggles on each completed frame
// Options     : `define ETHER_TX_PAD_EN pads short payloads with zero dibits
//               up to MIN_PAYLOAD_BYTES before the FCS.
// Revision    : 1.0 - initial release
// ============================================================================
module ether_tx #(
    parameter int MAX_PAYLOAD_BYTES = 1500,
    parameter int IFG_CYCLES        = 48,
    parameter int MIN_PAYLOAD_BYTES = 46
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       preamble_signal,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       data_request,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       truncated,
    output logic       led
);

    localparam logic [31:0] c_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] c_CRC_INIT  = 32'hFFFF_FFFF;
    localparam int          c_DIBIT_CAP = 4 * MAX_PAYLOAD_BYTES;
    localparam int          c_DIBIT_MIN = 4 * MIN_PAYLOAD_BYTES;
    localparam int          c_DCNT_MAX  = (c_DIBIT_CAP > c_DIBIT_MIN) ? c_DIBIT_CAP : c_DIBIT_MIN;
    localparam int          c_DCNT_W    = $clog2(c_DCNT_MAX + 1);
    localparam int          c_PH_MAX    = (IFG_CYCLES > 32) ? IFG_CYCLES : 32;
    localparam int          c_PCNT_W    = $clog2(c_PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_FCS      = 3'd3,
        S_IFG      = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_PCNT_W-1:0]   r_pcnt;
    logic [c_DCNT_W-1:0]   r_dcnt;
    logic [31:0]           r_crc;
    logic                  r_txen;
    logic [1:0]            r_txd;
    logic                  r_dreq;
    logic                  r_busy;
    logic                  r_trunc;
    logic                  r_led;

    logic [c_DCNT_W-1:0]   w_next_dcnt;
    logic                  w_cap_hit;

    // Two serial CRC steps per dibit; bit 0 is first on the wire.
    function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? c_POLY : 32'h0);
        end
        return c;
    endfunction

    assign w_next_dcnt = r_dcnt + 1'b1;
    assign w_cap_hit   = (w_next_dcnt == c_DCNT_W'(c_DIBIT_CAP));

`ifdef ETHER_TX_PAD_EN
    logic r_padding;
    logic w_pad_start;
    logic w_pad_done;

    // Real data ended short of the minimum frame: switch to zero fill.
    assign w_pad_start = !axiiv && (r_dcnt != '0) && (r_dcnt < c_DCNT_W'(c_DIBIT_MIN));
    assign w_pad_done  = (w_next_dcnt == c_DCNT_W'(c_DIBIT_MIN));
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_pcnt  <= '0;
            r_dcnt  <= '0;
            r_crc   <= c_CRC_INIT;
            r_txen  <= 1'b0;
            r_txd   <= 2'b00;
            r_dreq  <= 1'b0;
            r_busy  <= 1'b0;
            r_trunc <= 1'b0;
            r_led   <= 1'b0;
`ifdef ETHER_TX_PAD_EN
            r_padding <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txen <= 1'b0;
                    r_txd  <= 2'b00;
                    if (preamble_signal) begin
                        r_state <= S_PREAMBLE;
                        r_busy  <= 1'b1;
                        r_trunc <= 1'b0;
                        r_crc   <= c_CRC_INIT;
                        r_dcnt  <= '0;
                        r_pcnt  <= '0;
                        // First preamble dibit goes out with the start edge.
                        r_txen  <= 1'b1;
                        r_txd   <= 2'b01;
                    end
                end

                S_PREAMBLE: begin
                    r_pcnt <= r_pcnt + 1'b1;
                    if (r_pcnt == c_PCNT_W'(30)) begin
                        // SFD dibit; data_request leads PAYLOAD by one cycle.
                        r_txd   <= 2'b11;
                        r_dreq  <= 1'b1;
                        r_pcnt  <= '0;
                        r_state <= S_PAYLOAD;
                    end else begin
                        r_txd <= 2'b01;
                    end
                end

                S_PAYLOAD: begin
`ifdef ETHER_TX_PAD_EN
                    if (r_padding || w_pad_start) begin
                        r_txen    <= 1'b1;
                        r_txd     <= 2'b00;
                        r_crc     <= crc_dibit(r_crc, 2'b00);
                        r_dcnt    <= w_next_dcnt;
                        r_dreq    <= 1'b0;
                        r_padding <= 1'b1;
                        if (w_pad_done) begin
                            r_padding <= 1'b0;
                            r_pcnt    <= '0;
                            r_state   <= S_FCS;
                        end
                    end else
`endif
                    if (axiiv) begin
                        r_txen <= 1'b1;
                        r_txd  <= axiid;
                        r_crc  <= crc_dibit(r_crc, axiid);
                        r_dcnt <= w_next_dcnt;
                        if (w_cap_hit) begin
                            r_trunc <= 1'b1;
                            r_dreq  <= 1'b0;
                            r_pcnt  <= '0;
                            r_state <= S_FCS;
                        end
                    end else if (r_dcnt != '0) begin
                        // Burst ended: the CRC is final, so the first FCS
                        // dibit goes out now to keep txen contiguous.
                        r_txen  <= 1'b1;
                        r_txd   <= ~r_crc[1:0];
                        r_crc   <= r_crc >> 2;
                        r_dreq  <= 1'b0;
                        r_pcnt  <= c_PCNT_W'(1);
                        r_state <= S_FCS;
                    end else begin
                        r_txen <= 1'b0;
                        r_txd  <= 2'b00;
                    end
                end

                S_FCS: begin
                    r_txen <= 1'b1;
                    r_txd  <= ~r_crc[1:0];
                    r_crc  <= r_crc >> 2;
                    r_pcnt <= r_pcnt + 1'b1;
                    if (r_pcnt == c_PCNT_W'(15)) begin
                        r_pcnt  <= '0;
                        r_state <= S_IFG;
                    end
                end

                S_IFG: begin
                    r_txen <= 1'b0;
                    r_txd  <= 2'b00;
                    r_pcnt <= r_pcnt + 1'b1;
                    if (r_pcnt == c_PCNT_W'(IFG_CYCLES - 1)) begin
                        r_pcnt  <= '0;
                        r_busy  <= 1'b0;
                        r_led   <= ~r_led;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_txen  <= 1'b0;
                    r_txd   <= 2'b00;
                    r_dreq  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_request = r_dreq;
    assign axiov        = r_txen;
    assign axiod        = r_txd;
    assign busy         = r_busy;
    assign truncated    = r_trunc;
    assign led          = r_led;

endmodule
`default_nettype wire

// File: tb/tb_ether_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ether_tx
// Description : Directed self-checking bench for ether_tx. A second instance
//               with a 4-byte payload cap exercises truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ether_tx;

    localparam logic [31:0] c_POLY = 32'hEDB8_8320;
`ifdef ETHER_TX_PAD_EN
    localparam bit c_PAD = 1'b1;
`else
    localparam bit c_PAD = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       pre_m, pre_t;
    logic       axiiv;
    logic [1:0] axiid;

    logic       dr_m, axiov_m, busy_m, trunc_m, led_m;
    logic [1:0] axiod_m;
    logic       dr_t, axiov_t, busy_t, trunc_t, led_t;
    logic [1:0] axiod_t;

    ether_tx dut (
        .clk(clk), .rstn(rstn), .preamble_signal(pre_m),
        .axiiv(axiiv), .axiid(axiid),
        .data_request(dr_m), .axiov(axiov_m), .axiod(axiod_m),
        .busy(busy_m), .truncated(trunc_m), .led(led_m)
    );

    ether_tx #(.MAX_PAYLOAD_BYTES(4)) dut_t (
        .clk(clk), .rstn(rstn), .preamble_signal(pre_t),
        .axiiv(axiiv), .axiid(axiid),
        .data_request(dr_t), .axiov(axiov_t), .axiod(axiod_t),
        .busy(busy_t), .truncated(trunc_t), .led(led_t)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmit capture
    logic [1:0] cap[$];
    int         cap_cyc[$];
    logic [1:0] cap_t[$];
    int         frames_m = 0;
    int         last_v_m = 0;
    int         busy_fall_m = 0;
    int         dr_t_fall = 0;
    logic       pv_m = 1'b0, pb_m = 1'b0, pdr_t = 1'b0;

    always @(negedge clk) begin
        if (axiov_m) begin
            cap.push_back(axiod_m);
            cap_cyc.push_back(cyc);
            last_v_m <= cyc;
        end
        if (axiov_m && !pv_m) frames_m <= frames_m + 1;
        if (!busy_m && pb_m) busy_fall_m <= cyc;
        if (axiov_t) cap_t.push_back(axiod_t);
        if (!dr_t && pdr_t) dr_t_fall <= cyc;
        pv_m  <= axiov_m;
        pb_m  <= busy_m;
        pdr_t <= dr_t;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] pl [0:63];

    function automatic logic [31:0] crc_model(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c >> 1) ^ (((c[0] ^ pl[i][b]) == 1'b1) ? c_POLY : 32'h0);
        return ~c;
    endfunction

    task automatic send(input bit tgt, input int n_bytes, input int abort_at,
                        input int stray_at, output int drv0, output int drv_end);
        int k;
        drv0 = -1;
        drv_end = -1;
        if (tgt) pre_t = 1'b1; else pre_m = 1'b1;
        @(negedge clk);
        pre_t = 1'b0;
        pre_m = 1'b0;
        k = 0;
        while (!(tgt ? dr_t : dr_m) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            check("dreq_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < 4 * n_bytes; i++) begin
            if (i == abort_at) begin
                check("pre_rst_txen", 64'(axiov_m), 1);
                #3 rstn = 1'b0;
                #1;
                check("async_txen", 64'(axiov_m), 0);
                check("async_txd", 64'(axiod_m), 0);
                check("async_busy", 64'(busy_m), 0);
                axiiv = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            axiiv = 1'b1;
            axiid = pl[i / 4][2 * (i % 4) +: 2];
            if (i == 0) drv0 = cyc;
            if (i == stray_at) pre_m = 1'b1;
            @(negedge clk);
            pre_m = 1'b0;
        end
        axiiv = 1'b0;
        axiid = 2'b00;
        drv_end = cyc;
    endtask

    task automatic wait_idle(input bit tgt);
        int k;
        k = 0;
        while ((tgt ? busy_t : busy_m) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        int k;
        k = 0;
        while (cyc < target && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic chk_frame(input string tag, input bit tgt, input int n_dib, input logic [31:0] fcs_exp);
        logic [1:0]  q[$];
        logic [31:0] fcs;
        int          pe, pm;
        if (tgt) q = cap_t; else q = cap;
        check({tag, "_len"}, 64'(q.size()), 64'(32 + n_dib + 16));
        if (q.size() == 32 + n_dib + 16) begin
            pe = 0;
            for (int i = 0; i < 31; i++) if (q[i] != 2'b01) pe++;
            if (q[31] != 2'b11) pe++;
            check({tag, "_preamble_errs"}, 64'(pe), 0);
            pm = 0;
            for (int i = 0; i < n_dib; i++)
                if (q[32 + i] != pl[i / 4][2 * (i % 4) +: 2]) pm++;
            check({tag, "_payload_errs"}, 64'(pm), 0);
            fcs = '0;
            for (int i = 0; i < 16; i++) fcs[2 * i +: 2] = q[32 + n_dib + i];
            check({tag, "_fcs"}, 64'(fcs), 64'(fcs_exp));
        end
    endtask

    int d0, de, f0;

    initial begin
        rstn  = 1'b0;
        pre_m = 1'b0;
        pre_t = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;

        // Reset values with inputs toggling
        repeat (4) begin
            @(negedge clk);
            pre_m = ~pre_m;
            axiiv = ~axiiv;
            axiid = axiid + 2'd1;
        end
        @(negedge clk);
        check("rst_axiov", 64'(axiov_m), 0);
        check("rst_axiod", 64'(axiod_m), 0);
        check("rst_dreq", 64'(dr_m), 0);
        check("rst_busy", 64'(busy_m), 0);
        check("rst_trunc", 64'(trunc_m), 0);
        check("rst_led", 64'(led_m), 0);
        pre_m = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", 64'(busy_m), 0);
        check("idle_axiov", 64'(axiov_m), 0);

        // Basic frame "123456789"
        for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
        cap.delete();
        cap_cyc.delete();
        send(1'b0, 9, -1, -1, d0, de);
        wait_idle(1'b0);
        chk_frame("basic", 1'b0, 36, 32'hCBF4_3926);
        if (cap_cyc.size() > 32) begin
            check("dreq_lead", 64'(d0), 64'(cap_cyc[31]));
            check("latency", 64'(cap_cyc[32]), 64'(d0 + 1));
        end else begin
            check("basic_capture", 0, 1);
        end
        check("ifg_len", 64'(busy_fall_m - last_v_m), 48);
        check("basic_busy", 64'(busy_m), 0);
        check("basic_dreq", 64'(dr_m), 0);
        check("basic_led", 64'(led_m), 1);
        check("basic_trunc", 64'(trunc_m), 0);

        // Start requests while busy are ignored
        for (int i = 0; i < 4; i++) pl[i] = 8'h31 + 8'(i);
        cap.delete();
        cap_cyc.delete();
        f0 = frames_m;
        send(1'b0, 4, -1, 5, d0, de);
        wait_cyc(de + 16 + 20);
        pre_m = 1'b1;
        @(negedge clk);
        pre_m = 1'b0;
        wait_cyc(de + 16 + 47);
        pre_m = 1'b1;
        @(negedge clk);
        pre_m = 1'b0;
        wait_idle(1'b0);
        repeat (60) @(negedge clk);
        check("busy_frames", 64'(frames_m - f0), 1);
        check("busy_after", 64'(busy_m), 0);
        chk_frame("busy", 1'b0, 16, crc_model(4));
        check("busy_led", 64'(led_m), 0);

        // Truncation on the 4-byte-cap instance
        for (int i = 0; i < 8; i++) pl[i] = 8'h31 + 8'(i);
        cap_t.delete();
        send(1'b1, 8, -1, -1, d0, de);
        wait_idle(1'b1);
        chk_frame("trunc", 1'b1, 16, crc_model(4));
        check("trunc_flag", 64'(trunc_t), 1);
        check("trunc_dreq_fall", 64'(dr_t_fall), 64'(d0 + 16));
        pl[0] = 8'h5A;
        cap_t.delete();
        send(1'b1, 1, -1, -1, d0, de);
        wait_idle(1'b1);
        check("trunc_cleared", 64'(trunc_t), 0);
        chk_frame("short_t", 1'b1, 4, crc_model(1));

        // Asynchronous reset mid-payload, then a clean frame
        for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
        send(1'b0, 9, 10, -1, d0, de);
        repeat (3) @(negedge clk);
        check("post_rst_led", 64'(led_m), 0);
        cap.delete();
        cap_cyc.delete();
        send(1'b0, 9, -1, -1, d0, de);
        wait_idle(1'b0);
        chk_frame("recover", 1'b0, 36, 32'hCBF4_3926);
        check("recover_led", 64'(led_m), 1);

        // One-byte payload: padded to 46 bytes only when the option is built in
        pl[0] = 8'hAB;
        for (int i = 1; i < 46; i++) pl[i] = 8'h00;
        cap.delete();
        cap_cyc.delete();
        send(1'b0, 1, -1, -1, d0, de);
        wait_idle(1'b0);
        if (c_PAD) chk_frame("pad", 1'b0, 184, crc_model(46));
        else       chk_frame("nopad", 1'b0, 4, crc_model(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ether_tx.md
Name: ether_tx

Overview:
- RMII transmit framer; last stage of the output path, directly downstream of bitorder_out.
- On a start pulse it drives the following onto eth_txen/eth_txd:
  - preamble + SFD,
  - the wire-ordered payload dibits from bitorder_out,
  - a computed CRC-32 FCS,
  - the mandatory inter-frame gap.
- Paces the upstream compiler through data_request.
- Runs at the 50 MHz eth_refclk, 2 bits/cycle.

Parameters:
- MAX_PAYLOAD_BYTES, 1500, payload cap; longer streams are truncated.
- IFG_CYCLES, 48, idle dibit cycles after the FCS (96 bit times).
- MIN_PAYLOAD_BYTES, 46, pad target when ETHER_TX_PAD_EN is defined.

Ports:
- clk, input, 1: eth_refclk, 50 MHz.
- rstn, input, 1: asynchronous, active-low reset.
- preamble_signal, input, 1: one-cycle frame start request (from matrix_compiler compile_done).
- axiiv, input, 1: payload dibit valid (from bitorder_out).
- axiid, input, 2: payload dibit; axiid[0] is the earlier wire bit.
- data_request, output, 1: high while the block accepts payload.
- axiov, output, 1: eth_txen.
- axiod, output, 2: eth_txd.
- busy, output, 1: high from accepted start through end of IFG.
- truncated, output, 1: sticky; set when the cap is hit, cleared on next accepted start.
- led, output, 1: toggles on each completed frame.

Behaviour:
- Reset: all outputs 0; FSM IDLE; CRC = 0xFFFFFFFF; counters 0.
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rstn).
- Reset mid-frame: axiov/axiod drop to 0 asynchronously; no partial FCS is emitted.
- All outputs are registered.
- FSM: IDLE -> PREAMBLE -> PAYLOAD -> FCS -> IFG -> IDLE.
- IDLE:
  - preamble_signal=1 -> PREAMBLE next cycle; busy=1.
  - preamble_signal while busy is ignored.
- PREAMBLE: 32 cycles, axiov=1.
  - axiod=2'b01 for cycles 0-30; 2'b11 on cycle 31 (SFD 0xD5).
  - data_request rises on cycle 31, so upstream sees it one cycle before PAYLOAD.
- PAYLOAD:
  - Each cycle with axiiv=1: axiod<=axiid, axiov=1, CRC advances by 2 bits, dibit count++.
  - Data handshake: upstream presents a contiguous burst.
  - First axiiv=0 after at least one dibit has been accepted ends the payload.
  - axiiv=0 before the first dibit: wait, holding axiov=0 (payload not started; no limit).
  - On exit: data_request falls next edge; transition to FCS.
  - At 4*MAX_PAYLOAD_BYTES dibits: truncated<=1, data_request<=0, -> FCS; further axiiv ignored.
  - Partial bytes (dibit count not a multiple of 4) are sent as-is; no alignment fix.
- CRC:
  - Reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF.
  - Two serial steps per dibit: axiid[0] first, then axiid[1].
- FCS: 16 cycles, axiov=1.
  - axiod = ~crc[1:0], then crc shifted right by 2 each cycle (LSB-first bytes on wire).
- IFG: IFG_CYCLES cycles, axiov=0, axiod=0.
  - Then IDLE, busy=0, led toggles.
  - preamble_signal arriving in the IFG cycle that returns to IDLE is dropped.
- Latency: payload dibit on axiid at edge N appears on axiod after edge N+1.

Optional Feature:
- Macro: ETHER_TX_PAD_EN.
- Defined: if the payload ends below 4*MIN_PAYLOAD_BYTES dibits, the FSM stays in PAYLOAD and emits 2'b00 dibits (axiov=1, CRC included) until the minimum is reached, then FCS. data_request drops when real data ends.
- Undefined: no padding; short frames are sent as-is.

Test Plan:
- Reset values: hold rstn=0, toggle inputs -> axiov=0, axiod=0, data_request=0, busy=0, truncated=0; release -> stays IDLE.
- Basic frame: preamble_signal pulse, payload ASCII "123456789" (36 dibits contiguous) ->
  - 31×01, then 11;
  - then payload echoed one cycle late;
  - then FCS bytes 0x26,0x39,0xF4,0xCB LSB-first (16 dibits);
  - then 48 idle cycles; busy low after; led toggled.
- Truncation: with MAX_PAYLOAD_BYTES=4, stream 8 bytes -> exactly 16 payload dibits sent, FCS over first 4 bytes, truncated=1, data_request falls at dibit 16.
- Start while busy: second preamble_signal during PAYLOAD and during IFG -> ignored; exactly one frame transmitted.
- Async reset mid-payload: rstn low between edges -> axiov 0 immediately; after release, new start yields a clean frame with correct FCS.
- Padding: with ETHER_TX_PAD_EN, 1-byte payload 0xAB ->
  - 4 data dibits + 180 zero dibits (46 bytes total);
  - FCS matches CRC-32 of 0xAB followed by 45×0x00.
  - Without the macro: 4 dibits then FCS.
